// File: rtl/cpu24_pkg.sv
// cpu24_pkg: shared constants, branch/ALU encodings and the EX->MEM queue entry layout.
package cpu24_pkg;
    localparam int WIDTH = 24;
    localparam int RD_W = 4;
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_LT   = 2'b11
    } br_type_e;
    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5
    } alu_op_e;
    // Entry layout, LSB first: MemWrite, MemRead, RegWrite, RegDst, StoreData, Result
    localparam int ENTRY_W = 2 * WIDTH + RD_W + 3;
    localparam int OFF_MW = 0;
    localparam int OFF_MR = 1;
    localparam int OFF_RW = 2;
    localparam int OFF_RD = 3;
    localparam int OFF_SD = OFF_RD + RD_W;
    localparam int OFF_RES = OFF_SD + WIDTH;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry valid/ready FIFO with flush; ready depends only on registered count.
module skid_fifo2 #(
    parameter int W = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = !rst && (count < 2'(DEPTH));
    assign out_valid = count != 2'd0;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: captures ALU results, resolves branches, keeps Z/N/V/C flags and
// queues non-branch instructions toward MEM through a 2-entry FIFO.
module ex_mem_stage
    import cpu24_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluZero,
    input  logic             AluOverflow,
    input  logic             AluCarryOut,
    input  logic [WIDTH-1:0] StoreData,
    input  logic [RD_W-1:0]  RegDst,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             SetFlags,
    input  logic [1:0]       BrType,
    input  logic [WIDTH-1:0] BrTarget,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutResult,
    output logic [WIDTH-1:0] OutStoreData,
    output logic [RD_W-1:0]  OutRegDst,
    output logic             OutRegWrite,
    output logic             OutMemRead,
    output logic             OutMemWrite,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagV,
    output logic             FlagC,
    output logic             BranchTaken,
    output logic [WIDTH-1:0] BranchTarget
);
    logic               accept;
    logic               is_branch;
    logic               taken;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;

    assign accept    = InValid && InReady && !Flush;
    assign is_branch = BrType != BR_NONE;
    assign entry_in  = {AluResult, StoreData, RegDst, RegWrite, MemRead, MemWrite};

    // ALU computes A-B for branches, so BLT is sign of the difference corrected by overflow
    always_comb
        taken = (BrType == BR_EQ) ? AluZero :
                (BrType == BR_NE) ? !AluZero :
                (BrType == BR_LT) ? (AluResult[WIDTH-1] ^ AluOverflow) : 1'b0;

    skid_fifo2 #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (Clock),
        .rst       (Reset),
        .flush     (Flush),
        .in_valid  (InValid && !Flush && !is_branch),
        .in_ready  (InReady),
        .in_data   (entry_in),
        .out_valid (OutValid),
        .out_ready (OutReady),
        .out_data  (entry_out)
    );

    assign OutResult    = entry_out[OFF_RES +: WIDTH];
    assign OutStoreData = entry_out[OFF_SD +: WIDTH];
    assign OutRegDst    = entry_out[OFF_RD +: RD_W];
    assign OutRegWrite  = entry_out[OFF_RW];
    assign OutMemRead   = entry_out[OFF_MR];
    assign OutMemWrite  = entry_out[OFF_MW];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            {FlagZ, FlagN, FlagV, FlagC} <= 4'b0;
            BranchTaken  <= 1'b0;
            BranchTarget <= '0;
        end else begin
            if (accept && SetFlags)
                {FlagZ, FlagN, FlagV, FlagC} <= {AluZero, AluResult[WIDTH-1], AluOverflow, AluCarryOut};
            BranchTaken <= accept && taken;
            if (accept && taken)
                BranchTarget <= BrTarget;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of queueing, flags, branch resolution, flush and reset.
module tb_ex_mem_stage;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [23:0] AluResult = '0;
    logic        AluZero = 1'b0;
    logic        AluOverflow = 1'b0;
    logic        AluCarryOut = 1'b0;
    logic [23:0] StoreData = '0;
    logic [3:0]  RegDst = '0;
    logic        RegWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        SetFlags = 1'b0;
    logic [1:0]  BrType = 2'b00;
    logic [23:0] BrTarget = '0;
    logic        Flush = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [23:0] OutResult;
    logic [23:0] OutStoreData;
    logic [3:0]  OutRegDst;
    logic        OutRegWrite;
    logic        OutMemRead;
    logic        OutMemWrite;
    logic        FlagZ;
    logic        FlagN;
    logic        FlagV;
    logic        FlagC;
    logic        BranchTaken;
    logic [23:0] BranchTarget;
    int          errors = 0;
    int          checks = 0;

    ex_mem_stage dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow),
        .AluCarryOut(AluCarryOut), .StoreData(StoreData), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .SetFlags(SetFlags), .BrType(BrType), .BrTarget(BrTarget), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
        .OutStoreData(OutStoreData), .OutRegDst(OutRegDst), .OutRegWrite(OutRegWrite),
        .OutMemRead(OutMemRead), .OutMemWrite(OutMemWrite), .FlagZ(FlagZ),
        .FlagN(FlagN), .FlagV(FlagV), .FlagC(FlagC), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Presents one instruction at a negedge and returns at the following negedge.
    task automatic drive(input logic [23:0] res, input logic [23:0] sd, input logic [3:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic sf,
                         input logic z, input logic v, input logic c,
                         input logic [1:0] bt, input logic [23:0] tgt);
        AluResult = res; StoreData = sd; RegDst = rd; RegWrite = rw; MemRead = mr;
        MemWrite = mw; SetFlags = sf; AluZero = z; AluOverflow = v; AluCarryOut = c;
        BrType = bt; BrTarget = tgt; InValid = 1'b1;
        @(negedge Clock);
        InValid = 1'b0; SetFlags = 1'b0; BrType = 2'b00;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready: got %b want 0", InReady); end
        checks++; if (OutResult !== 24'h0) begin errors++; $display("FAIL reset_outresult: got %h want 0", OutResult); end
        checks++; if ({FlagZ, FlagN, FlagV, FlagC} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {FlagZ, FlagN, FlagV, FlagC}); end
        checks++; if (BranchTaken !== 1'b0 || BranchTarget !== 24'h0) begin errors++; $display("FAIL reset_branch: got %b/%h want 0/0", BranchTaken, BranchTarget); end
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL release_inready: got %b want 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL release_outvalid: got %b want 0", OutValid); end
    endtask

    task automatic test_alu;
        OutReady = 1'b1;
        drive(24'd2, 24'h0, 4'd3, 1, 0, 0, 1, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL alu_outvalid: got %b want 1", OutValid); end
        checks++; if (OutResult !== 24'd2) begin errors++; $display("FAIL alu_result: got %h want 000002", OutResult); end
        checks++; if (OutRegDst !== 4'd3 || OutRegWrite !== 1'b1) begin errors++; $display("FAIL alu_regdst: got %0d/%b want 3/1", OutRegDst, OutRegWrite); end
        checks++; if (FlagZ !== 1'b0 || FlagN !== 1'b0) begin errors++; $display("FAIL alu_flags_zn: got %b%b want 00", FlagZ, FlagN); end
        @(negedge Clock);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL alu_popped: got %b want 0", OutValid); end
        drive(24'h800000, 24'hABCDEF, 4'd5, 0, 0, 1, 1, 0, 1, 1, 2'b00, 24'h0);
        checks++; if (OutResult !== 24'h800000 || OutStoreData !== 24'hABCDEF) begin errors++; $display("FAIL store_data: got %h/%h want 800000/abcdef", OutResult, OutStoreData); end
        checks++; if ({OutRegWrite, OutMemRead, OutMemWrite} !== 3'b001) begin errors++; $display("FAIL store_ctrl: got %b want 001", {OutRegWrite, OutMemRead, OutMemWrite}); end
        checks++; if ({FlagZ, FlagN, FlagV, FlagC} !== 4'b0111) begin errors++; $display("FAIL store_flags: got %b want 0111", {FlagZ, FlagN, FlagV, FlagC}); end
        @(negedge Clock);
    endtask

    task automatic test_branch;
        OutReady = 1'b1;
        drive(24'h0, 24'h0, 4'd1, 1, 0, 0, 0, 1, 0, 0, 2'b01, 24'h000040);
        checks++; if (BranchTaken !== 1'b1 || BranchTarget !== 24'h000040) begin errors++; $display("FAIL beq_taken: got %b/%h want 1/000040", BranchTaken, BranchTarget); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL beq_no_enqueue: got %b want 0", OutValid); end
        @(negedge Clock);
        checks++; if (BranchTaken !== 1'b0) begin errors++; $display("FAIL beq_pulse_len: got %b want 0", BranchTaken); end
        drive(24'h0, 24'h0, 4'd1, 1, 0, 0, 0, 1, 0, 0, 2'b10, 24'h000040);
        checks++; if (BranchTaken !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b want 0", BranchTaken); end
        drive(24'hFFFFFB, 24'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 24'h000100);
        checks++; if (BranchTaken !== 1'b1 || BranchTarget !== 24'h000100) begin errors++; $display("FAIL blt_neg: got %b/%h want 1/000100", BranchTaken, BranchTarget); end
        drive(24'h7FFFFF, 24'h0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 24'h000200);
        checks++; if (BranchTaken !== 1'b1 || BranchTarget !== 24'h000200) begin errors++; $display("FAIL blt_ovf: got %b/%h want 1/000200", BranchTaken, BranchTarget); end
        drive(24'h000002, 24'h0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 24'h000300);
        checks++; if (BranchTaken !== 1'b0) begin errors++; $display("FAIL blt_pos: got %b want 0", BranchTaken); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL blt_no_enqueue: got %b want 0", OutValid); end
        @(negedge Clock);
    endtask

    task automatic test_backpressure;
        OutReady = 1'b0;
        drive(24'd7, 24'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b want 1", InReady); end
        drive(24'd9, 24'h0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", InReady); end
        drive(24'd11, 24'h0, 4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutResult !== 24'd7 || InReady !== 1'b0) begin errors++; $display("FAIL bp_hold: got %h/%b want 000007/0", OutResult, InReady); end
        OutReady = 1'b1;
        @(negedge Clock);
        checks++; if (OutValid !== 1'b1 || OutResult !== 24'd9) begin errors++; $display("FAIL bp_second: got %b/%h want 1/000009", OutValid, OutResult); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b want 1", InReady); end
        @(negedge Clock);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", OutValid); end
    endtask

    task automatic test_back_to_back;
        OutReady = 1'b1;
        drive(24'h000011, 24'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutResult !== 24'h000011) begin errors++; $display("FAIL b2b_first: got %h want 000011", OutResult); end
        drive(24'h000022, 24'h0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutResult !== 24'h000022 || OutValid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b want 000022/1", OutResult, OutValid); end
        drive(24'h000033, 24'h0, 4'd3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutResult !== 24'h000033 || InReady !== 1'b1) begin errors++; $display("FAIL b2b_third: got %h/%b want 000033/1", OutResult, InReady); end
        @(negedge Clock);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", OutValid); end
    endtask

    task automatic test_flush;
        OutReady = 1'b0;
        drive(24'd5, 24'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        drive(24'd6, 24'h0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        Flush = 1'b1;
        drive(24'h0, 24'h0, 4'd4, 1, 0, 0, 1, 1, 0, 0, 2'b01, 24'h000080);
        Flush = 1'b0;
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL flush_full: got %b/%b want 0/1", OutValid, InReady); end
        checks++; if (FlagZ !== 1'b0 || BranchTaken !== 1'b0) begin errors++; $display("FAIL flush_full_side: got %b/%b want 0/0", FlagZ, BranchTaken); end
        drive(24'd5, 24'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        Flush = 1'b1;
        drive(24'h0, 24'h0, 4'd4, 1, 0, 0, 1, 1, 0, 0, 2'b01, 24'h000080);
        Flush = 1'b0;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_one: got %b want 0", OutValid); end
        checks++; if (FlagZ !== 1'b0 || BranchTaken !== 1'b0) begin errors++; $display("FAIL flush_one_side: got %b/%b want 0/0", FlagZ, BranchTaken); end
        OutReady = 1'b1;
        drive(24'h000066, 24'h0, 4'd6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        checks++; if (OutValid !== 1'b1 || OutResult !== 24'h000066) begin errors++; $display("FAIL post_flush: got %b/%h want 1/000066", OutValid, OutResult); end
        @(negedge Clock);
    endtask

    task automatic test_midreset;
        OutReady = 1'b0;
        drive(24'h000077, 24'h0, 4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        drive(24'h000088, 24'h0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 24'h0);
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (OutValid !== 1'b0 || OutResult !== 24'h0 || InReady !== 1'b0) begin errors++; $display("FAIL midreset_queue: got %b/%h/%b want 0/000000/0", OutValid, OutResult, InReady); end
        checks++; if ({FlagN, FlagV, FlagC} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b want 000", {FlagN, FlagV, FlagC}); end
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin errors++; $display("FAIL midreset_release: got %b/%b want 1/0", InReady, OutValid); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Downstream consumer of the 24-bit ALU in the EX stage.
- Captures the ALU outputs (Result, Zero, Overflow, CarryOut) together with the instruction's control bits.
- Resolves conditional branches, maintains the architectural Z/N/V/C flag register, and buffers results in a 2-entry valid/ready queue toward the MEM stage, so MEM back-pressure never corrupts EX results.

Parameters:
- WIDTH, 24, datapath width (ALU Result, store data, branch target).
- RD_W, 4, destination register index width (16 GPRs).
- DEPTH, 2, queue entries; only 2 is supported.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  EX holds a valid instruction.
- InReady  output  1  stage can accept this cycle.
- AluResult  input  WIDTH  ALU Result.
- AluZero  input  1  ALU Zero.
- AluOverflow  input  1  ALU Overflow.
- AluCarryOut  input  1  ALU CarryOut.
- StoreData  input  WIDTH  rt value for stores.
- RegDst  input  RD_W  destination register.
- RegWrite / MemRead / MemWrite  input  1 each  control bits.
- SetFlags  input  1  update the flag register.
- BrType  input  2  00 none, 01 BEQ, 10 BNE, 11 BLT.
- BrTarget  input  WIDTH  branch target address.
- Flush  input  1  discard queue contents and the incoming instruction.
- OutValid  output  1  queue head valid.
- OutReady  input  1  MEM accepts the head.
- OutResult  output  WIDTH  head result.
- OutStoreData  output  WIDTH  head store data.
- OutRegDst  output  RD_W  head destination register.
- OutRegWrite / OutMemRead / OutMemWrite  output  1 each  head control bits.
- FlagZ / FlagN / FlagV / FlagC  output  1 each  architectural flags.
- BranchTaken  output  1  one-cycle pulse.
- BranchTarget  output  WIDTH  valid when BranchTaken.

Behaviour:
- Reset (synchronous, active-high):
  - Count, pointers, flags, BranchTaken and BranchTarget go to 0.
  - OutValid=0; all Out* data outputs read 0.
  - InReady=0 while Reset is high; InReady=1 on the first cycle after.
  - Reset mid-operation discards all entries and any pending branch pulse.
- Accept: accept = InValid & InReady & !Flush. InReady = !Reset & (count<2), combinational from registered count only; it never depends on OutReady, so there is no combinational path from OutReady to InReady.
- Enqueue: on accept with BrType==00, push {AluResult, StoreData, RegDst, RegWrite, MemRead, MemWrite}. Branch instructions (BrType!=00) are consumed and never enqueued.
- Dequeue: pop = OutValid & OutReady. OutValid = (count!=0). Out* are driven from the head entry (registered storage).
- Simultaneous push and pop at count==1: count stays 1; the new entry becomes head on the next cycle.
- At count==2, InReady=0; a pop frees a slot visible the next cycle. Pointers are 1 bit and wrap modulo 2.
- Flush: next cycle count=0 and OutValid=0. The incoming instruction is dropped, with no flag update and no branch. Flush beats push and pop in the same cycle.
- Flags: on accept with SetFlags=1, the next cycle holds FlagZ=AluZero, FlagN=AluResult[WIDTH-1], FlagV=AluOverflow, FlagC=AluCarryOut. Flags are otherwise held and are unaffected by queue state.
- Branch resolution, on accept (ALU is doing A-B with BNegate=1):
  - BEQ is taken if AluZero.
  - BNE is taken if !AluZero.
  - BLT is taken if AluResult[WIDTH-1]^AluOverflow (signed less-than).
  - BranchTaken and BranchTarget are registered: the pulse appears exactly 1 cycle after accept and lasts 1 cycle.
  - The stage does not self-flush; the fetch unit drives Flush from BranchTaken.
- Latency: 1 cycle from accept to OutValid when the queue is empty. Throughput is 1 per cycle when OutReady is held high.

Decomposition:
- Shared package cpu24_pkg:
  - WIDTH=24 and RD_W=4 constants.
  - BrType encodings BR_NONE/BR_EQ/BR_NE/BR_LT.
  - ALU Op encodings.
  - Packed queue-entry field offsets (entry width = 2*WIDTH+RD_W+3).
- One sub-module, skid_fifo2: a generic 2-entry valid/ready FIFO (count, pointers, flush) parameterised by entry width.
- ex_mem_stage itself holds the flag register, branch logic, and entry packing/unpacking.

Test Plan:
1. Reset held 2 cycles, then released → all outputs 0 during reset, InReady=1 the cycle after release, OutValid=0.
2. AluResult=2 (10-8), SetFlags=1, RegWrite=1, RegDst=3, OutReady=1 → next cycle OutValid=1, OutResult=2, OutRegDst=3, FlagZ=0, FlagN=0; entry popped; OutValid=0 the following cycle.
3. BEQ with AluZero=1 (10-10), BrTarget=24'h000040 → BranchTaken=1 for exactly 1 cycle, 1 cycle after accept, BranchTarget=24'h000040, no enqueue. BNE with the same inputs → BranchTaken stays 0.
4. BLT with AluResult=24'hFFFFFB (5-10), AluOverflow=0 → taken. AluResult=24'h7FFFFF with AluOverflow=1 → taken. AluResult=24'h000002 with AluOverflow=0 → not taken.
5. OutReady=0, push results 7 then 9 → InReady=0 at count 2, third InValid is held off. Raise OutReady → outputs 7 then 9 in order, InReady=1 again the cycle after the first pop.
6. Queue holding 2 entries, Flush=1 together with InValid=1, SetFlags=1, AluZero=1 → next cycle OutValid=0, InReady=1, FlagZ unchanged, no BranchTaken.
